snake_motion_engine: RTL



---
 rtl/snake_pkg.sv | 39 +++
 rtl/snake_tick_gen.sv | 30 +++
 rtl/snake_motion_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake motion engine: direction codes,
// grid geometry, FSM states and the segment position payload.
package snake_pkg;

  localparam int unsigned COORD_W = 6;
  localparam int unsigned GRID_W  = 64;
  localparam int unsigned GRID_H  = 48;
  localparam int unsigned START_X = 32;
  localparam int unsigned START_Y = 24;
  localparam int unsigned NSEG    = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [1:0]         dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  // Index 0 is the head, NSEG-1 the tail.
  typedef pos_t [NSEG-1:0] body_t;

  // Opposite pairs differ only in the low bit (up/down, left/right).
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Movement tick counter: counts enabled cycles modulo TICK_DIV and flags the
// terminal count combinationally so the step lands on that same edge.
module snake_tick_gen #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == LAST);

endmodule

// File: rtl/snake_motion_engine.sv
// Snake body owner: FSM, direction filter and 4-segment shift register that
// feed registered segment cell coordinates to the renderer.
module snake_motion_engine
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter int unsigned GRID_W   = snake_pkg::GRID_W,
  parameter int unsigned GRID_H   = snake_pkg::GRID_H,
  parameter int unsigned START_X  = snake_pkg::START_X,
  parameter int unsigned START_Y  = snake_pkg::START_Y,
  parameter bit          WRAP     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dir_valid,
  input  logic [1:0]         dir,
  input  logic               pause,
  input  logic               restart,
  output logic [COORD_W-1:0] Px1,
  output logic [COORD_W-1:0] Px2,
  output logic [COORD_W-1:0] Px3,
  output logic [COORD_W-1:0] Px4,
  output logic [COORD_W-1:0] Py1,
  output logic [COORD_W-1:0] Py2,
  output logic [COORD_W-1:0] Py3,
  output logic [COORD_W-1:0] Py4,
  output logic               step_pulse,
  output logic               crashed,
  output logic               running
);

  localparam coord_t X_MAX = COORD_W'(GRID_W - 1);
  localparam coord_t Y_MAX = COORD_W'(GRID_H - 1);

  function automatic body_t init_body();
    body_t b;
    for (int i = 0; i < int'(NSEG); i++) begin
      b[i].x = COORD_W'(int'(START_X) - i);
      b[i].y = COORD_W'(START_Y);
    end
    return b;
  endfunction

  state_t state_q, state_d;
  dir_t   cur_q, cur_d, pend_q, pend_d;
  body_t  body_q, body_d;
  logic   step_d;
  logic   tc_c, tick_en, tick_clr;
  logic   step_now, hit_wall;
  pos_t   head_nxt;
  dir_t   ref_dir;

  assign tick_en  = (state_q == RUN) && !pause;
  assign tick_clr = restart || (state_q != RUN);

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (tick_clr),
    .tc_c (tc_c)
  );

  // Next head cell in pend direction, with edge detection (compare-and-select).
  always_comb begin
    head_nxt = body_q[0];
    hit_wall = 1'b0;
    case (pend_q)
      DIR_UP: begin
        hit_wall   = (body_q[0].y == '0);
        head_nxt.y = hit_wall ? Y_MAX : body_q[0].y - COORD_W'(1);
      end
      DIR_DOWN: begin
        hit_wall   = (body_q[0].y == Y_MAX);
        head_nxt.y = hit_wall ? '0 : body_q[0].y + COORD_W'(1);
      end
      DIR_LEFT: begin
        hit_wall   = (body_q[0].x == '0);
        head_nxt.x = hit_wall ? X_MAX : body_q[0].x - COORD_W'(1);
      end
      default: begin
        hit_wall   = (body_q[0].x == X_MAX);
        head_nxt.x = hit_wall ? '0 : body_q[0].x + COORD_W'(1);
      end
    endcase
  end

  // FSM next-state, direction filter and body shift.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    body_d   = body_q;
    step_d   = 1'b0;
    step_now = tc_c && !pause;
    ref_dir  = cur_q;
    if (restart) begin
      state_d = IDLE;
      cur_d   = DIR_RIGHT;
      pend_d  = DIR_RIGHT;
      body_d  = init_body();
    end else begin
      case (state_q)
        IDLE: begin
          if (dir_valid && (dir != opposite(cur_q))) begin
            pend_d  = dir;
            state_d = RUN;
          end
        end
        RUN: begin
          if (step_now) begin
            ref_dir = pend_q;
            if (hit_wall && !WRAP) begin
              state_d = DEAD;
            end else begin
              cur_d  = pend_q;
              body_d = {body_q[NSEG-2:0], head_nxt};
              step_d = 1'b1;
            end
          end
          if (dir_valid && (dir != opposite(ref_dir))) begin
            pend_d = dir;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      body_q     <= init_body();
      step_pulse <= 1'b0;
      crashed    <= 1'b0;
      running    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      body_q     <= body_d;
      step_pulse <= step_d;
      crashed    <= (state_d == DEAD);
      running    <= (state_d == RUN);
    end
  end

  assign Px1 = body_q[0].x;
  assign Px2 = body_q[1].x;
  assign Px3 = body_q[2].x;
  assign Px4 = body_q[3].x;
  assign Py1 = body_q[0].y;
  assign Py2 = body_q[1].y;
  assign Py3 = body_q[2].y;
  assign Py4 = body_q[3].y;

endmodule
